// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_IDX_W / REG_DATA_W : geometry of the 4-entry, 32-bit register file
//   arb_state_t            : arbiter FSM states
//   rr_pick()              : round-robin search helper, up to MAX_REQ requesters
package regfile_pkg;

  localparam int REG_IDX_W  = 2;
  localparam int REG_DATA_W = 32;
  localparam int MAX_REQ    = 8;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] winner;
  } rr_pick_t;

  // First set bit of valid, scanning ptr, ptr+1, ... modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int unsigned        nreq);
    rr_pick_t    r;
    int unsigned p;
    logic [2:0]  j;
    r.found  = 1'b0;
    r.winner = 3'd0;
    p        = 32'(ptr);
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        j = 3'((p + k) % nreq);
        if (!r.found && valid[j]) begin
          r.found  = 1'b1;
          r.winner = j;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Purely combinational round-robin priority pick.
//   valid  : request vector (NREQ bits)
//   ptr    : requester with highest priority this cycle
//   found  : at least one request present
//   winner : id of the selected requester (meaningful only when found)
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] winner
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]         ptr_ext;
  rr_pick_t           pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    ptr_ext               = '0;
    ptr_ext[PTR_W-1:0]    = ptr;
    pick                  = rr_pick(valid_ext, ptr_ext, NREQ);
    found                 = pick.found;
    // Narrow the 3-bit package result back to this instance's id width.
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick.winner == 3'(i)) winner = PTR_W'(i);
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port among NREQ requesters.
// Round-robin grant with per-requester valid/ready handshake and a lock mode
// giving the current owner back-to-back grants. The write_* outputs are
// registered (one cycle after the handshake) and drive the register file.
// Writes to index 0 are accepted but not enabled (reg0 is hardwired zero).
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_lock    : per-requester request and lock-hold
//   req_index/req_data    : packed per-requester target index and data
//   req_ready             : combinational one-hot (or zero) grant
//   write_enable/index/data, grant_id : registered write beat
//   locked                : FSM is in the locked state
// Optional build macro REGFILE_WR_ARBITER_STATS_EN adds stat_grants
// (per-requester 16-bit saturating transfer counts) and stat_dropped
// (saturating count of index-0 discards).
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = REG_DATA_W,
  parameter int IDX_W  = REG_IDX_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_lock,
  input  logic [NREQ*IDX_W-1:0]     req_index,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      write_enable,
  output logic [IDX_W-1:0]          write_index,
  output logic [DATA_W-1:0]         write_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
`ifdef REGFILE_WR_ARBITER_STATS_EN
  output logic [NREQ*16-1:0]        stat_grants,
  output logic [15:0]               stat_dropped,
`endif
  output logic                      locked
);

  localparam int ID_W = $clog2(NREQ);

  arb_state_t        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   owner;

  logic              arb_found;
  logic [ID_W-1:0]   arb_winner;
  logic              xfer_p0;
  logic [ID_W-1:0]   xfer_id_p0;
  logic [IDX_W-1:0]  xfer_index_p0;
  logic [DATA_W-1:0] xfer_data_p0;
  logic [ID_W-1:0]   next_ptr;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  rr_arbiter #(.NREQ(NREQ), .PTR_W(ID_W)) u_rr (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .found  (arb_found),
    .winner (arb_winner)
  );

  // ---- stage p0: grant decision (combinational) ----
  always_comb begin
    req_ready  = '0;
    xfer_p0    = 1'b0;
    xfer_id_p0 = arb_winner;
    if (state == ARB_LOCKED) begin
      // Owner only; everyone else stalls even while the owner is idle.
      req_ready[owner] = req_valid[owner];
      xfer_p0          = req_valid[owner];
      xfer_id_p0       = owner;
    end else if (arb_found) begin
      req_ready[arb_winner] = 1'b1;
      xfer_p0               = 1'b1;
    end
  end

  assign xfer_index_p0 = req_index[xfer_id_p0*IDX_W +: IDX_W];
  assign xfer_data_p0  = req_data[xfer_id_p0*DATA_W +: DATA_W];
  assign next_ptr      = (arb_winner == ID_W'(NREQ-1)) ? '0 : arb_winner + 1'b1;
  assign locked        = (state == ARB_LOCKED);

  // ---- stage p1: FSM update and registered write beat ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      write_enable <= 1'b0;
      write_index  <= '0;
      write_data   <= '0;
      grant_id     <= '0;
    end else begin
      write_enable <= xfer_p0 && (xfer_index_p0 != '0);
      if (xfer_p0) begin
        write_index <= xfer_index_p0;
        write_data  <= xfer_data_p0;
        grant_id    <= xfer_id_p0;
      end
      case (state)
        ARB_IDLE: begin
          if (xfer_p0) begin
            rr_ptr <= next_ptr;
            if (req_lock[arb_winner]) begin
              state <= ARB_LOCKED;
              owner <= arb_winner;
            end
          end
        end
        ARB_LOCKED: begin
          // The exit cycle still served only the owner; arbitration resumes next cycle.
          if (!req_lock[owner]) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef REGFILE_WR_ARBITER_STATS_EN
  logic [15:0] grant_cnt [NREQ];
  logic [15:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
      drop_cnt <= '0;
    end else if (xfer_p0) begin
      grant_cnt[xfer_id_p0] <= sat_inc(grant_cnt[xfer_id_p0]);
      if (xfer_index_p0 == '0) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = grant_cnt[g];
  end
  assign stat_dropped = drop_cnt;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  localparam int NREQ   = 3;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ*IDX_W-1:0]  req_index;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   write_enable;
  logic [IDX_W-1:0]       write_index;
  logic [DATA_W-1:0]      write_data;
  logic [1:0]             grant_id;
  logic                   locked;
`ifdef REGFILE_WR_ARBITER_STATS_EN
  logic [NREQ*16-1:0]     stat_grants;
  logic [15:0]            stat_dropped;
`endif

  regfile_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_lock     (req_lock),
    .req_index    (req_index),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .write_enable (write_enable),
    .write_index  (write_index),
    .write_data   (write_data),
    .grant_id     (grant_id),
`ifdef REGFILE_WR_ARBITER_STATS_EN
    .stat_grants  (stat_grants),
    .stat_dropped (stat_dropped),
`endif
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers following the arbitration rules.
  int          m_rr, m_own;
  bit          m_lk;
  bit          m_we;
  int          m_widx, m_gid;
  logic [31:0] m_wdata;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [NREQ-1:0] v);
    if (m_lk) return v[m_own] ? m_own : -1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check ready before the edge, outputs after it.
  task automatic apply(input logic [2:0] v, input logic [2:0] l, input logic [5:0] idx,
                       input logic [95:0] data, input logic r, output logic [2:0] ready_seen);
    int   g;
    bit   was_lk;
    logic [2:0] exp_ready;
    @(negedge clk);
    req_valid = v; req_lock = l; req_index = idx; req_data = data; reset = r;
    #1;
    ready_seen = req_ready;
    g = m_pick(v);
    exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
    if (!r) chk("ready_model", req_ready, exp_ready);
    @(posedge clk);
    #1;
    if (r) begin
      m_rr = 0; m_own = 0; m_lk = 0; m_we = 0; m_widx = 0; m_wdata = 0; m_gid = 0;
    end else begin
      was_lk = m_lk;
      m_we   = 0;
      if (g >= 0) begin
        m_widx  = (idx >> (2*g)) & 3;
        m_wdata = data[32*g +: 32];
        m_gid   = g;
        m_we    = (m_widx != 0);
        if (!was_lk) begin
          m_rr = (g + 1) % NREQ;
          if (l[g]) begin m_lk = 1; m_own = g; end
        end
      end
      if (was_lk && !l[m_own]) m_lk = 0;
    end
    chk("we_model",     write_enable, m_we);
    chk("widx_model",   write_index,  m_widx[1:0]);
    chk("wdata_model",  write_data,   m_wdata);
    chk("gid_model",    grant_id,     m_gid[1:0]);
    chk("locked_model", locked,       m_lk);
  endtask

  typedef struct {
    logic [2:0]  v;
    logic [2:0]  l;
    logic [5:0]  idx;
    logic [95:0] data;
    logic [2:0]  ready;
    logic        we;
    logic [1:0]  widx;
    logic [31:0] wdata;
    logic [1:0]  gid;
    logic        lck;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0] rdy;
    vec_t       t;

    // Round-robin over three requesters, indices 1/2/3.
    for (int k = 0; k < 3; k++) begin
      t.v = 3'b111; t.l = 3'b000; t.idx = 6'b11_10_01;
      t.data = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      t.ready = 3'(1 << k); t.we = 1; t.widx = 2'(k + 1);
      t.wdata = t.data[32*k +: 32]; t.gid = 2'(k); t.lck = 0;
      vecs.push_back(t);
    end
    // Single requester at full throughput.
    for (int k = 0; k < 4; k++) begin
      t.v = 3'b010; t.l = 3'b000; t.idx = 6'b00_10_00;
      t.data = {32'h0, 32'h1234_0000 + 32'(k), 32'h0};
      t.ready = 3'b010; t.we = 1; t.widx = 2; t.wdata = 32'h1234_0000 + 32'(k);
      t.gid = 1; t.lck = 0;
      vecs.push_back(t);
    end
    // Index-0 write is accepted but discarded; pointer wraps 2 -> 0.
    t.v = 3'b100; t.l = 3'b000; t.idx = 6'b00_00_00;
    t.data = {32'hDEAD_BEEF, 64'h0};
    t.ready = 3'b100; t.we = 0; t.widx = 0; t.wdata = 32'hDEAD_BEEF; t.gid = 2; t.lck = 0;
    vecs.push_back(t);
    // Requester 0 locks for three beats while requester 2 waits.
    for (int k = 0; k < 3; k++) begin
      t.v = 3'b101; t.l = 3'b001; t.idx = 6'b11_00_01;
      t.data = {32'hC0C0_C0C0, 32'h0, 32'h0000_0A00 + 32'(k)};
      t.ready = 3'b001; t.we = 1; t.widx = 1; t.wdata = 32'h0000_0A00 + 32'(k);
      t.gid = 0; t.lck = 1;
      vecs.push_back(t);
    end
    // Lock dropped: exit cycle still owner-only.
    t.v = 3'b101; t.l = 3'b000; t.idx = 6'b11_00_01;
    t.data = {32'hC0C0_C0C0, 32'h0, 32'h0000_0A03};
    t.ready = 3'b001; t.we = 1; t.widx = 1; t.wdata = 32'h0000_0A03; t.gid = 0; t.lck = 0;
    vecs.push_back(t);
    // Arbitration resumes from pointer 1: requester 2 wins.
    t.ready = 3'b100; t.widx = 3; t.wdata = 32'hC0C0_C0C0; t.gid = 2;
    vecs.push_back(t);

    // Reset and reset values.
    m_rr = 0; m_own = 0; m_lk = 0; m_we = 0; m_widx = 0; m_wdata = 0; m_gid = 0;
    apply(3'b000, 3'b000, '0, '0, 1'b1, rdy);
    apply(3'b111, 3'b111, '1, '1, 1'b1, rdy);
    chk("rst_we",     write_enable, 1'b0);
    chk("rst_widx",   write_index,  2'd0);
    chk("rst_wdata",  write_data,   32'd0);
    chk("rst_gid",    grant_id,     2'd0);
    chk("rst_locked", locked,       1'b0);
    apply(3'b000, 3'b000, '0, '0, 1'b0, rdy);
    chk("idle_ready", rdy, 3'b000);

    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].l, vecs[i].idx, vecs[i].data, 1'b0, rdy);
      chk($sformatf("vec%0d_ready", i),  rdy,          vecs[i].ready);
      chk($sformatf("vec%0d_we", i),     write_enable, vecs[i].we);
      chk($sformatf("vec%0d_widx", i),   write_index,  vecs[i].widx);
      chk($sformatf("vec%0d_wdata", i),  write_data,   vecs[i].wdata);
      chk($sformatf("vec%0d_gid", i),    grant_id,     vecs[i].gid);
      chk($sformatf("vec%0d_locked", i), locked,       vecs[i].lck);
`ifdef REGFILE_WR_ARBITER_STATS_EN
      if (i == 7) chk("stat_dropped", stat_dropped, 16'd1);
`endif
    end

    // Reset in the middle of a lock with a beat pending.
    apply(3'b001, 3'b001, 6'b00_00_01, {64'h0, 32'h5555_0001}, 1'b0, rdy);
    chk("lock_enter", locked, 1'b1);
    apply(3'b101, 3'b001, 6'b11_00_01, {32'h7, 32'h0, 32'h5555_0002}, 1'b1, rdy);
    chk("midrst_locked", locked,       1'b0);
    chk("midrst_we",     write_enable, 1'b0);
    chk("midrst_wdata",  write_data,   32'd0);
    apply(3'b110, 3'b000, 6'b10_01_00, {32'h2222_2222, 32'h1111_1111, 32'h0}, 1'b0, rdy);
    chk("postrst_ready", rdy,          3'b010);
    chk("postrst_gid",   grant_id,     2'd1);
    chk("postrst_wdata", write_data,   32'h1111_1111);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  rv, rl;
      logic [5:0]  ri;
      logic [95:0] rd;
      rv = 3'($urandom_range(0, 7));
      rl = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      ri = 6'($urandom_range(0, 63));
      rd = {$urandom, $urandom, $urandom};
      apply(rv, rl, ri, rd, ($urandom_range(0, 49) == 0), rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
